// File: rtl/scurve_multi_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scurve_multi_counter_if                                              |
// | Control, trigger and readout stream bundle of the S-curve counter.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface scurve_multi_counter_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
);
  logic [N_CH-1:0]  Trigger;
  logic             CLK_EXT;
  logic             Test_Start;
  logic [CNT_W-1:0] CPT_MAX;
  logic [N_CH-1:0]  Ch_Mask;
  logic [CNT_W-1:0] Out_Data;
  logic             Out_Valid;
  logic             Out_Last;
  logic             Out_Ready;
  logic             CPT_DONE;
  logic             Busy;

  modport master (
    output Trigger, CLK_EXT, Test_Start, CPT_MAX, Ch_Mask, Out_Ready,
    input  Out_Data, Out_Valid, Out_Last, CPT_DONE, Busy
  );

  modport slave (
    input  Trigger, CLK_EXT, Test_Start, CPT_MAX, Ch_Mask, Out_Ready,
    output Out_Data, Out_Valid, Out_Last, CPT_DONE, Busy
  );
endinterface
`default_nettype wire

// File: rtl/scurve_multi_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scurve_multi_counter                                                 |
// | Counts CLK_EXT pulses and gated per-channel trigger falls, then      |
// | streams the counts out. SCURVE_SAT_EN: trigger counters saturate.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module scurve_multi_counter #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  wire logic             Clk,
  input  wire logic             reset_n,
  scurve_multi_counter_if.slave io
);
  localparam int                 c_idx_w    = $clog2(N_CH + 1);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_CH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COUNT   = 2'd1,
    S_READOUT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic            r_ext_s1, r_ext_s2, r_ext_s3;
  logic [N_CH-1:0] r_trg_s1, r_trg_s2, r_trg_s3;
  logic            w_ext_rise, w_ext_fall, w_gate, w_start;
  logic [N_CH-1:0] w_trg_fall;

  logic [CNT_W-1:0] r_max_lat;
  logic [CNT_W-1:0] r_pulse_cnt;
  logic [N_CH-1:0]  r_mask;
  logic [CNT_W-1:0] w_trig_cnt [N_CH];

  logic [c_idx_w-1:0] r_idx;
  logic [CNT_W-1:0]   r_out_data;
  logic               r_out_valid;
  logic               r_out_last;
  logic [CNT_W-1:0]   w_cur_word;
  logic [CNT_W-1:0]   w_nxt_word;
  logic               w_hs;
  logic               w_last_hs;

  // Triggers idle high, so their synchronisers reset to 1 to avoid a phantom fall.
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_ext_s1 <= 1'b0;
      r_ext_s2 <= 1'b0;
      r_ext_s3 <= 1'b0;
      r_trg_s1 <= '1;
      r_trg_s2 <= '1;
      r_trg_s3 <= '1;
    end else begin
      r_ext_s1 <= io.CLK_EXT;
      r_ext_s2 <= r_ext_s1;
      r_ext_s3 <= r_ext_s2;
      r_trg_s1 <= io.Trigger;
      r_trg_s2 <= r_trg_s1;
      r_trg_s3 <= r_trg_s2;
    end
  end

  assign w_ext_rise = r_ext_s2 & ~r_ext_s3;
  assign w_ext_fall = ~r_ext_s2 & r_ext_s3;
  assign w_trg_fall = ~r_trg_s2 & r_trg_s3;
  assign w_gate     = (r_state == S_COUNT) & r_ext_s2;
  assign w_start    = (r_state == S_IDLE) & io.Test_Start;

  always_ff @(posedge Clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (io.Test_Start) w_state_next = S_COUNT;
      end
      S_COUNT: begin
        if (!io.Test_Start)                                 w_state_next = S_IDLE;
        else if (r_max_lat == '0)                           w_state_next = S_READOUT;
        else if ((r_pulse_cnt == r_max_lat) && w_ext_fall)  w_state_next = S_READOUT;
      end
      S_READOUT: begin
        if (w_last_hs) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (!io.Test_Start) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_pulse_cnt <= '0;
      r_max_lat   <= '0;
      r_mask      <= '0;
    end else if (w_start) begin
      r_pulse_cnt <= '0;
      r_max_lat   <= io.CPT_MAX;
      r_mask      <= io.Ch_Mask;
    end else if ((r_state == S_COUNT) && w_ext_rise && (r_pulse_cnt != r_max_lat)) begin
      r_pulse_cnt <= r_pulse_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge Clk) begin
      if (!reset_n) begin
        r_cnt <= '0;
      end else if (w_start) begin
        r_cnt <= '0;
      end else if (w_gate && w_trg_fall[g] && r_mask[g]) begin
`ifdef SCURVE_SAT_EN
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
`else
        r_cnt <= r_cnt + 1'b1;
`endif
      end
    end

    assign w_trig_cnt[g] = r_cnt;
  end

  // Word k of the stream is trig_cnt[k-1]; word 0 is the pulse count.
  always_comb begin
    w_cur_word = r_pulse_cnt;
    w_nxt_word = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (r_idx == c_idx_w'(k + 1)) w_cur_word = w_trig_cnt[k];
      if (r_idx == c_idx_w'(k))     w_nxt_word = w_trig_cnt[k];
    end
  end

  assign w_hs      = r_out_valid & io.Out_Ready;
  assign w_last_hs = w_hs & r_out_last;

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (r_state == S_READOUT) begin
      if (!r_out_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_cur_word;
        r_out_last  <= (r_idx == c_last_idx);
      end else if (w_hs) begin
        if (r_out_last) begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end else begin
          r_idx      <= r_idx + 1'b1;
          r_out_data <= w_nxt_word;
          r_out_last <= ((r_idx + 1'b1) == c_last_idx);
        end
      end
    end else begin
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign io.Out_Data  = r_out_data;
  assign io.Out_Valid = r_out_valid;
  assign io.Out_Last  = r_out_last;
  assign io.CPT_DONE  = (r_state == S_DONE);
  assign io.Busy      = (r_state != S_IDLE);
endmodule
`default_nettype wire
